// File: rtl/led_string_pkg.sv
// Shared definitions for the LED string serializer and its upstream scheduler:
// FSM encoding, default NRZ timing constants and tick/brightness helpers.
package led_string_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam int DEF_CLK_PERIOD_NS = 50;
    localparam int DEF_DATA_WIDTH    = 24;
    localparam int DEF_T0H_NS        = 400;
    localparam int DEF_T1H_NS        = 800;
    localparam int DEF_BIT_NS        = 1250;
    localparam int DEF_LATCH_US      = 280;

    function automatic int ns_to_ticks(input int ns, input int clk_ns);
        return ns / clk_ns;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Scales one 8-bit colour channel by (brightness+1)/256; 8'hFF is identity.
    function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, ch} * ({8'd0, br} + 16'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Loadable down-counter with a terminal-count strobe, shared by bit-phase and latch timing.
module led_bit_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    // A load of N-1 makes tc assert N cycles after the load edge.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != W'(0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(0));

endmodule

// File: rtl/led_string_serializer.sv
// WS2812-class NRZ serializer for one LED string with a one-pixel holding register.
// Optional macro LED_STRING_BRIGHTNESS_EN adds a brightness[7:0] scaler applied at accept.
module led_string_serializer
    import led_string_pkg::*;
#(
    parameter int CLK_PERIOD_NS = DEF_CLK_PERIOD_NS,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int T0H_NS        = DEF_T0H_NS,
    parameter int T1H_NS        = DEF_T1H_NS,
    parameter int BIT_NS        = DEF_BIT_NS,
    parameter int LATCH_US      = DEF_LATCH_US
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] pixel_data,
    input  logic                  pixel_data_valid,
    input  logic                  h_blank,
    output logic                  sdi,
    output logic                  string_ready
`ifdef LED_STRING_BRIGHTNESS_EN
    ,
    input  logic [7:0]            brightness
`endif
);

    localparam int T0H    = ns_to_ticks(T0H_NS, CLK_PERIOD_NS);
    localparam int T1H    = ns_to_ticks(T1H_NS, CLK_PERIOD_NS);
    localparam int TBIT   = ns_to_ticks(BIT_NS, CLK_PERIOD_NS);
    localparam int TLATCH = ns_to_ticks(LATCH_US * 1000, CLK_PERIOD_NS);
    localparam int CNT_W  = $clog2(max_int(TBIT, TLATCH) + 1);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] LD_T0H   = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] LD_T1H   = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] LD_T0L   = CNT_W'(TBIT - T0H - 1);
    localparam logic [CNT_W-1:0] LD_T1L   = CNT_W'(TBIT - T1H - 1);
    localparam logic [CNT_W-1:0] LD_LATCH = CNT_W'(TLATCH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    hold_full_q, hold_full_d;
    logic                    blank_pend_q, blank_pend_d;
    logic                    sdi_q, sdi_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   pix_in_s;
    logic                    accept_s;
    logic                    tmr_load_s;
    logic [CNT_W-1:0]        tmr_val_s;
    logic                    tmr_tc_s;

    function automatic logic [CNT_W-1:0] high_load(input logic b);
        return b ? LD_T1H : LD_T0H;
    endfunction

    function automatic logic [CNT_W-1:0] low_load(input logic b);
        return b ? LD_T1L : LD_T0L;
    endfunction

`ifdef LED_STRING_BRIGHTNESS_EN
    assign pix_in_s = {scale_channel(pixel_data[23:16], brightness),
                       scale_channel(pixel_data[15:8],  brightness),
                       scale_channel(pixel_data[7:0],   brightness)};
`else
    assign pix_in_s = pixel_data;
`endif

    assign accept_s = pixel_data_valid && ready_q;

    led_bit_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .tc       (tmr_tc_s)
    );

    // Handshake, holding register, latch request and bit-sequencing FSM.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        bit_cnt_d    = bit_cnt_q;
        blank_pend_d = blank_pend_q || h_blank;
        tmr_load_s   = 1'b0;
        tmr_val_s    = LD_T0H;

        if (accept_s) begin
            hold_d      = pix_in_s;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = BIT_LAST;
                    state_d     = ST_HIGH;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = high_load(hold_q[DATA_WIDTH-1]);
                end else if (blank_pend_q) begin
                    state_d    = ST_LATCH;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LD_LATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (tmr_tc_s) begin
                    state_d    = ST_LOW;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = low_load(shift_q[DATA_WIDTH-1]);
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (!tmr_tc_s) begin
                    state_d = ST_LOW;
                end else if (bit_cnt_q != BIT_W'(0)) begin
                    shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q - BIT_W'(1);
                    state_d    = ST_HIGH;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = high_load(shift_q[DATA_WIDTH-2]);
                end else if (hold_full_q) begin
                    // Reload straight into the next bit so consecutive pixels stay gap-free.
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = BIT_LAST;
                    state_d     = ST_HIGH;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = high_load(hold_q[DATA_WIDTH-1]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (tmr_tc_s) begin
                    blank_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sdi_d   = (state_q == ST_HIGH);
        ready_d = !hold_full_d && !blank_pend_d && (state_d != ST_LATCH);
    end

    // State and datapath registers; sdi trails the HIGH state by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= DATA_WIDTH'(0);
            hold_q       <= DATA_WIDTH'(0);
            bit_cnt_q    <= BIT_W'(0);
            hold_full_q  <= 1'b0;
            blank_pend_q <= 1'b0;
            sdi_q        <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_full_q  <= hold_full_d;
            blank_pend_q <= blank_pend_d;
            sdi_q        <= sdi_d;
            ready_q      <= ready_d;
        end
    end

    assign sdi          = sdi_q;
    assign string_ready = ready_q;

endmodule

// File: tb/tb_led_string_serializer.sv
// Scoreboard bench for led_string_serializer: stimulus queues expected pixels and
// string_ready rise cycles; independent monitors decode sdi pulses and ready edges.
module tb_led_string_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] pixel_data = 24'd0;
    logic        pixel_data_valid = 1'b0;
    logic        h_blank = 1'b0;
    logic        sdi;
    logic        string_ready;
`ifdef LED_STRING_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'hFF;
`endif

    led_string_serializer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .h_blank          (h_blank),
        .sdi              (sdi),
        .string_ready     (string_ready)
`ifdef LED_STRING_BRIGHTNESS_EN
        ,
        .brightness       (brightness)
`endif
    );

    always #25 clk = ~clk;

    typedef struct {
        logic [23:0] pix;
        int          rise;
    } exp_t;

    exp_t pix_q[$];
    int   rdy_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // sdi monitor: per-bit high time, bit period, first-rise cycle and decoded pixel.
    logic        m_prev = 1'b0;
    int          m_bidx = 0;
    int          m_hi = 0;
    int          m_last = 0;
    exp_t        m_cur;
    logic [23:0] m_acc = 24'd0;

    initial begin
        m_cur.pix  = 24'd0;
        m_cur.rise = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_prev = 1'b0;
                m_bidx = 0;
                m_hi   = 0;
            end else begin
                if (sdi && !m_prev) begin
                    if (m_bidx == 0) begin
                        check("pixel_expected", 64'(pix_q.size() > 0), 64'd1);
                        if (pix_q.size() > 0) begin
                            m_cur = pix_q.pop_front();
                            check("first_rise_cycle", 64'(cyc), 64'(m_cur.rise));
                        end
                    end else begin
                        check("bit_period", 64'(cyc - m_last), 64'd25);
                    end
                    m_last = cyc;
                    m_hi   = 1;
                end else if (sdi && m_prev) begin
                    m_hi++;
                end else if (!sdi && m_prev) begin
                    check("high_ticks", 64'(m_hi), m_cur.pix[23 - m_bidx] ? 64'd16 : 64'd8);
                    m_acc = {m_acc[22:0], (m_hi == 16)};
                    m_bidx++;
                    if (m_bidx == 24) begin
                        check("pixel_value", 64'(m_acc), 64'(m_cur.pix));
                        m_bidx = 0;
                    end
                end
                m_prev = sdi;
            end
        end
    end

    // string_ready monitor: every rising edge must match the next expected cycle.
    logic r_prev = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && string_ready && !r_prev) begin
                check("ready_expected", 64'(rdy_q.size() > 0), 64'd1);
                if (rdy_q.size() > 0) begin
                    check("ready_rise_cycle", 64'(cyc), 64'(rdy_q.pop_front()));
                end
            end
            r_prev = string_ready;
        end
    end

    // Offer one pixel once ready; exp_rise < 0 means the sdi rise is 2 cycles after accept.
    task automatic send(input logic [23:0] pix, input logic [23:0] exp_pix, input logic hb,
                        input int extra_hold, input int exp_rise, output int n);
        int   w;
        exp_t e;
        w = 0;
        while (!string_ready && w < 10000) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 64'(string_ready), 64'd1);
        pixel_data       = pix;
        pixel_data_valid = 1'b1;
        h_blank          = hb;
        n                = cyc + 1;
        e.pix            = exp_pix;
        e.rise           = (exp_rise < 0) ? n + 2 : exp_rise;
        pix_q.push_back(e);
        @(negedge clk);
        h_blank = 1'b0;
        repeat (extra_hold) @(negedge clk);
        pixel_data_valid = 1'b0;
        pixel_data       = 24'd0;
    endtask

    task automatic pulse_blank();
        h_blank = 1'b1;
        @(negedge clk);
        h_blank = 1'b0;
    endtask

    initial begin
        int n;
        int n1;
        int n2;

        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_sdi", 64'(sdi), 64'd0);
            check("reset_ready", 64'(string_ready), 64'd1);
        end

        // Single pixel.
        send(24'hA50F00, 24'hA50F00, 1'b0, 0, -1, n);
        rdy_q.push_back(n + 1);
        repeat (620) @(negedge clk);

        // Back-to-back: second pixel queued mid-shift, valid held past acceptance.
        send(24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, -1, n1);
        rdy_q.push_back(n1 + 1);
        repeat (100) @(negedge clk);
        send(24'h000000, 24'h000000, 1'b0, 5, n1 + 602, n2);
        rdy_q.push_back(n1 + 601);
        repeat (1250) @(negedge clk);

        // h_blank mid-pixel: pixel completes, one idle cycle, then 5600-cycle latch.
        send(24'h123456, 24'h123456, 1'b0, 0, -1, n);
        rdy_q.push_back(n + 1);
        repeat (50) @(negedge clk);
        pulse_blank();
        rdy_q.push_back(n + 6202);
        repeat (6300) @(negedge clk);

        // Accept and h_blank together, plus a second h_blank during the latch.
        send(24'h000001, 24'h000001, 1'b1, 0, -1, n);
        rdy_q.push_back(n + 6202);
        repeat (3000) @(negedge clk);
        pulse_blank();
        repeat (3300) @(negedge clk);

`ifdef LED_STRING_BRIGHTNESS_EN
        brightness = 8'h7F;
        send(24'hFF8040, 24'h7F4020, 1'b0, 0, -1, n);
        rdy_q.push_back(n + 1);
        brightness = 8'hFF;
        repeat (620) @(negedge clk);
`endif

        check("end_sdi", 64'(sdi), 64'd0);
        check("end_ready", 64'(string_ready), 64'd1);
        check("pixels_left", 64'(pix_q.size()), 64'd0);
        check("ready_rises_left", 64'(rdy_q.size()), 64'd0);
        check("monitor_bit_index", 64'(m_bidx), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
